arbiter_desc_fifo: RTL and testbench

Descriptor FIFO feeding the cached output-stationary arbiter with per-stage transfer descriptors (burst length, start address, stage tag). It replaces the arbiter's hardcoded config registers. A host/config loader pushes descriptors in stage order, and the arbiter pops one descriptor per transfer stage. Stage tags are checked against the arbiter's expected stage and mismatches are flagged.

---
 rtl/arbiter_pkg.sv | 17 +
 rtl/desc_fifo_mem.sv | 26 ++
 rtl/arbiter_desc_fifo.sv | 126 ++++++++++++
 tb/tb_arbiter_desc_fifo.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_pkg.sv
// Shared definitions for the output-stationary arbiter and its descriptor FIFO:
// stage encoding and descriptor field widths.
package arbiter_pkg;

    localparam int unsigned STAGE_WIDTH    = 2;
    localparam int unsigned DEF_ADDR_WIDTH = 32;
    localparam int unsigned DEF_CFG_WIDTH  = 16;

    // Read stages are CONFIG, WEIGHTS and ACT; PSUM is the write-back stage.
    typedef enum logic [STAGE_WIDTH-1:0] {
        STAGE_CONFIG  = 2'd0,
        STAGE_WEIGHTS = 2'd1,
        STAGE_ACT     = 2'd2,
        STAGE_PSUM    = 2'd3
    } stage_e;

endpackage

// File: rtl/desc_fifo_mem.sv
// Descriptor storage: synchronous write port, asynchronous read port, no reset.
module desc_fifo_mem #(
    parameter int unsigned WIDTH = 50,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             w_clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the pushed descriptor into the addressed slot.
    always_ff @(posedge w_clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/arbiter_desc_fifo.sv
// Descriptor FIFO: holds per-stage transfer descriptors pushed by the config
// loader and hands them to the arbiter one per stage, flagging stage mismatch,
// underflow and zero-length bursts with sticky error bits.
module arbiter_desc_fifo
    import arbiter_pkg::*;
#(
    parameter int unsigned MAIN_MEM_ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned CONFIG_WIDTH        = DEF_CFG_WIDTH,
    parameter int unsigned DEPTH               = 8,
    parameter int unsigned CNT_WIDTH           = $clog2(DEPTH) + 1
) (
    input  logic                           w_clock,
    input  logic                           w_reset,
    input  logic                           w_flush,
    input  logic                           w_push_valid,
    output logic                           w_push_ready,
    input  logic [STAGE_WIDTH-1:0]         w_push_stage,
    input  logic [CONFIG_WIDTH-1:0]        w_push_burst,
    input  logic [MAIN_MEM_ADDR_WIDTH-1:0] w_push_addr,
    input  logic                           w_pop,
    input  logic [STAGE_WIDTH-1:0]         w_expect_stage,
    output logic                           w_pop_valid,
    output logic [STAGE_WIDTH-1:0]         w_pop_stage,
    output logic [CONFIG_WIDTH-1:0]        w_pop_burst,
    output logic [MAIN_MEM_ADDR_WIDTH-1:0] w_pop_addr,
    output logic [CNT_WIDTH-1:0]           w_count,
    output logic                           w_err_stage,
    output logic                           w_err_underflow,
    output logic                           w_err_zero,
    input  logic                           w_clear_err
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned DATA_W = STAGE_WIDTH + CONFIG_WIDTH + MAIN_MEM_ADDR_WIDTH;

    localparam logic [0:0] OCC_EMPTY    = 1'b0;
    localparam logic [0:0] OCC_NONEMPTY = 1'b1;

    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] count_next;
    logic                 push_ready_q;
    logic [0:0]           occ_state;
    logic [DATA_W-1:0]    head;
    logic                 push_ok;
    logic                 pop_ok;
    logic                 zero_bad;
    logic                 under_bad;
    logic                 stage_bad;

    assign occ_state   = (count == '0) ? OCC_EMPTY : OCC_NONEMPTY;
    assign w_pop_valid = (occ_state == OCC_NONEMPTY);

    // Flush suppresses every push/pop effect in its cycle, including error reporting.
    assign push_ok   = !w_flush && w_push_valid && push_ready_q && (w_push_burst != '0);
    assign pop_ok    = !w_flush && w_pop && w_pop_valid;
    assign zero_bad  = !w_flush && w_push_valid && (w_push_burst == '0);
    assign under_bad = !w_flush && w_pop && !w_pop_valid;
    assign stage_bad = pop_ok && (w_pop_stage != w_expect_stage);

    desc_fifo_mem #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_mem (
        .w_clock (w_clock),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr),
        .wr_data ({w_push_stage, w_push_burst, w_push_addr}),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign w_pop_stage  = w_pop_valid ? head[DATA_W-1 -: STAGE_WIDTH] : '0;
    assign w_pop_burst  = w_pop_valid ? head[MAIN_MEM_ADDR_WIDTH +: CONFIG_WIDTH] : '0;
    assign w_pop_addr   = w_pop_valid ? head[MAIN_MEM_ADDR_WIDTH-1:0] : '0;
    assign w_count      = count;
    assign w_push_ready = push_ready_q;

    // Next occupancy from accepted push/pop; flush empties outright.
    always_comb begin
        count_next = count;
        if (w_flush) begin
            count_next = '0;
        end else if (push_ok && !pop_ok) begin
            count_next = count + CNT_WIDTH'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CNT_WIDTH'(1);
        end
    end

    // Pointer, occupancy and registered ready update.
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            push_ready_q <= 1'b1;
        end else begin
            count        <= count_next;
            push_ready_q <= (count_next != CNT_WIDTH'(DEPTH));
            if (w_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge w_clock or posedge w_reset) begin
        if (w_reset) begin
            w_err_stage     <= 1'b0;
            w_err_underflow <= 1'b0;
            w_err_zero      <= 1'b0;
        end else begin
            w_err_stage     <= (w_err_stage     && !w_clear_err) || stage_bad;
            w_err_underflow <= (w_err_underflow && !w_clear_err) || under_bad;
            w_err_zero      <= (w_err_zero      && !w_clear_err) || zero_bad;
        end
    end

endmodule

// File: tb/tb_arbiter_desc_fifo.sv
// Directed bench for arbiter_desc_fifo with DEPTH=8.
module tb_arbiter_desc_fifo;

    logic        w_clock = 1'b0;
    logic        w_reset;
    logic        w_flush;
    logic        w_push_valid;
    logic        w_push_ready;
    logic [1:0]  w_push_stage;
    logic [15:0] w_push_burst;
    logic [31:0] w_push_addr;
    logic        w_pop;
    logic [1:0]  w_expect_stage;
    logic        w_pop_valid;
    logic [1:0]  w_pop_stage;
    logic [15:0] w_pop_burst;
    logic [31:0] w_pop_addr;
    logic [3:0]  w_count;
    logic        w_err_stage;
    logic        w_err_underflow;
    logic        w_err_zero;
    logic        w_clear_err;

    int unsigned total = 0;
    int unsigned bad   = 0;

    arbiter_desc_fifo #(
        .MAIN_MEM_ADDR_WIDTH (32),
        .CONFIG_WIDTH        (16),
        .DEPTH               (8)
    ) dut (
        .w_clock         (w_clock),
        .w_reset         (w_reset),
        .w_flush         (w_flush),
        .w_push_valid    (w_push_valid),
        .w_push_ready    (w_push_ready),
        .w_push_stage    (w_push_stage),
        .w_push_burst    (w_push_burst),
        .w_push_addr     (w_push_addr),
        .w_pop           (w_pop),
        .w_expect_stage  (w_expect_stage),
        .w_pop_valid     (w_pop_valid),
        .w_pop_stage     (w_pop_stage),
        .w_pop_burst     (w_pop_burst),
        .w_pop_addr      (w_pop_addr),
        .w_count         (w_count),
        .w_err_stage     (w_err_stage),
        .w_err_underflow (w_err_underflow),
        .w_err_zero      (w_err_zero),
        .w_clear_err     (w_clear_err)
    );

    always #5 w_clock = ~w_clock;

    task automatic step();
        @(posedge w_clock);
        #1;
    endtask

    task automatic idle_inputs();
        w_flush        = 1'b0;
        w_push_valid   = 1'b0;
        w_push_stage   = 2'd0;
        w_push_burst   = 16'd0;
        w_push_addr    = 32'd0;
        w_pop          = 1'b0;
        w_expect_stage = 2'd0;
        w_clear_err    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        w_reset = 1'b1;
        step();
        step();
        w_reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", w_count); end
        total++; if (w_pop_valid !== 1'b0) begin bad++; $display("FAIL reset_pop_valid got=%b exp=0", w_pop_valid); end
        total++; if (w_push_ready !== 1'b1) begin bad++; $display("FAIL reset_push_ready got=%b exp=1", w_push_ready); end
        total++; if (w_pop_addr !== 32'd0 || w_pop_burst !== 16'd0 || w_pop_stage !== 2'd0) begin
            bad++; $display("FAIL reset_pop_data got=%h/%h/%h exp=0/0/0", w_pop_stage, w_pop_burst, w_pop_addr); end
        total++; if ({w_err_stage, w_err_underflow, w_err_zero} !== 3'b000) begin
            bad++; $display("FAIL reset_errors got=%b exp=000", {w_err_stage, w_err_underflow, w_err_zero}); end
    endtask

    task automatic test_single_push();
        do_reset();
        w_push_valid = 1'b1; w_push_stage = 2'd0; w_push_burst = 16'd16; w_push_addr = 32'h100;
        step();
        w_push_valid = 1'b0;
        total++; if (w_pop_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", w_pop_valid); end
        total++; if (w_pop_addr !== 32'h100) begin bad++; $display("FAIL single_addr got=%h exp=100", w_pop_addr); end
        total++; if (w_pop_burst !== 16'd16) begin bad++; $display("FAIL single_burst got=%0d exp=16", w_pop_burst); end
        total++; if (w_pop_stage !== 2'd0) begin bad++; $display("FAIL single_stage got=%0d exp=0", w_pop_stage); end
        total++; if (w_count !== 4'd1) begin bad++; $display("FAIL single_count got=%0d exp=1", w_count); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            w_push_valid = 1'b1;
            w_push_stage = 2'(i % 4);
            w_push_burst = 16'(i + 1);
            w_push_addr  = 32'h300 + 32'(i);
            step();
        end
        total++; if (w_push_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", w_push_ready); end
        total++; if (w_count !== 4'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", w_count); end
        // ninth push held while full
        w_push_stage = 2'd3; w_push_burst = 16'd9; w_push_addr = 32'h3FF;
        step();
        step();
        total++; if (w_count !== 4'd8) begin bad++; $display("FAIL ninth_count got=%0d exp=8", w_count); end
        total++; if (w_pop_addr !== 32'h300) begin bad++; $display("FAIL ninth_head got=%h exp=300", w_pop_addr); end
        w_push_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            total++; if (w_pop_addr !== 32'h300 + 32'(i) || w_pop_burst !== 16'(i + 1) || w_pop_stage !== 2'(i % 4)) begin
                bad++; $display("FAIL drain_%0d got=%h/%0d/%h exp=%0d/%0d/%h", i, w_pop_stage, w_pop_burst, w_pop_addr,
                                i % 4, i + 1, 32'h300 + 32'(i)); end
            w_pop = 1'b1; w_expect_stage = 2'(i % 4);
            step();
        end
        w_pop = 1'b0;
        total++; if (w_pop_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b exp=0", w_pop_valid); end
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL drain_count got=%0d exp=0", w_count); end
        total++; if (w_err_stage !== 1'b0) begin bad++; $display("FAIL drain_no_err got=%b exp=0", w_err_stage); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            w_push_valid = 1'b1; w_push_stage = 2'd1; w_push_burst = 16'd4; w_push_addr = 32'h200 + 32'(i);
            step();
        end
        for (int j = 0; j < 20; j++) begin
            total++; if (w_pop_addr !== 32'h200 + 32'(j)) begin
                bad++; $display("FAIL b2b_head_%0d got=%h exp=%h", j, w_pop_addr, 32'h200 + 32'(j)); end
            w_push_valid = 1'b1; w_push_addr = 32'h203 + 32'(j);
            w_pop = 1'b1; w_expect_stage = 2'd1;
            step();
            total++; if (w_count !== 4'd3) begin bad++; $display("FAIL b2b_count_%0d got=%0d exp=3", j, w_count); end
        end
        w_push_valid = 1'b0; w_pop = 1'b0;
    endtask

    task automatic test_stage_err();
        do_reset();
        w_push_valid = 1'b1; w_push_stage = 2'd1; w_push_burst = 16'd4; w_push_addr = 32'h400;
        step();
        w_push_valid = 1'b0;
        w_pop = 1'b1; w_expect_stage = 2'd2;
        step();
        w_pop = 1'b0;
        total++; if (w_err_stage !== 1'b1) begin bad++; $display("FAIL stage_err_set got=%b exp=1", w_err_stage); end
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL stage_err_consumed got=%0d exp=0", w_count); end
        w_clear_err = 1'b1;
        step();
        w_clear_err = 1'b0;
        total++; if (w_err_stage !== 1'b0) begin bad++; $display("FAIL stage_err_clear got=%b exp=0", w_err_stage); end
    endtask

    task automatic test_underflow_zero();
        do_reset();
        w_pop = 1'b1;
        step();
        w_pop = 1'b0;
        total++; if (w_err_underflow !== 1'b1) begin bad++; $display("FAIL underflow_set got=%b exp=1", w_err_underflow); end
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL underflow_count got=%0d exp=0", w_count); end
        w_push_valid = 1'b1; w_push_burst = 16'd0; w_push_addr = 32'h500;
        step();
        w_push_valid = 1'b0;
        total++; if (w_err_zero !== 1'b1) begin bad++; $display("FAIL zero_set got=%b exp=1", w_err_zero); end
        total++; if (w_count !== 4'd0 || w_pop_valid !== 1'b0) begin
            bad++; $display("FAIL zero_dropped got=%0d/%b exp=0/0", w_count, w_pop_valid); end
    endtask

    // Runs right after test_underflow_zero so its sticky flags must survive the flush.
    task automatic test_flush();
        for (int i = 0; i < 5; i++) begin
            w_push_valid = 1'b1; w_push_stage = 2'd2; w_push_burst = 16'd8; w_push_addr = 32'h600 + 32'(i);
            step();
        end
        total++; if (w_count !== 4'd5) begin bad++; $display("FAIL flush_pre_count got=%0d exp=5", w_count); end
        w_flush = 1'b1; w_push_addr = 32'h6FF;
        step();
        w_flush = 1'b0; w_push_valid = 1'b0;
        total++; if (w_count !== 4'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", w_count); end
        total++; if (w_pop_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", w_pop_valid); end
        total++; if (w_push_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", w_push_ready); end
        total++; if (w_err_zero !== 1'b1 || w_err_underflow !== 1'b1) begin
            bad++; $display("FAIL flush_keeps_err got=%b%b exp=11", w_err_zero, w_err_underflow); end
        // new push after flush lands at slot 0 and is the head
        w_push_valid = 1'b1; w_push_addr = 32'h700;
        step();
        w_push_valid = 1'b0;
        total++; if (w_pop_addr !== 32'h700 || w_count !== 4'd1) begin
            bad++; $display("FAIL flush_repush got=%h/%0d exp=700/1", w_pop_addr, w_count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            w_push_valid = 1'b1; w_push_stage = 2'd3; w_push_burst = 16'd2; w_push_addr = 32'h800 + 32'(i);
            step();
        end
        w_push_valid = 1'b0;
        w_pop = 1'b1;
        step();
        step();
        step();
        w_pop = 1'b0;
        total++; if (w_err_underflow !== 1'b1) begin bad++; $display("FAIL async_pre_err got=%b exp=1", w_err_underflow); end
        #2;
        w_reset = 1'b1;
        #1;
        total++; if (w_count !== 4'd0 || w_pop_valid !== 1'b0 || w_push_ready !== 1'b1) begin
            bad++; $display("FAIL async_ctrl got=%0d/%b/%b exp=0/0/1", w_count, w_pop_valid, w_push_ready); end
        total++; if (w_err_underflow !== 1'b0 || w_err_stage !== 1'b0 || w_err_zero !== 1'b0) begin
            bad++; $display("FAIL async_err got=%b%b%b exp=000", w_err_stage, w_err_underflow, w_err_zero); end
        total++; if (w_pop_addr !== 32'd0) begin bad++; $display("FAIL async_data got=%h exp=0", w_pop_addr); end
        step();
        w_reset = 1'b0;
        step();
    endtask

    initial begin
        w_reset = 1'b1;
        idle_inputs();
        test_reset();
        test_single_push();
        test_fill_drain();
        test_back_to_back();
        test_stage_err();
        test_underflow_zero();
        test_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
